apb4_regfile_slave: RTL and testbench

Parametrised APB4 register-file slave, the next generation of the team's basic APB memory slave. Adds byte strobes (PSTRB), protection checking (PPROT), a read-only status window fed from the core, and real PSLVERR reporting for decode, alignment, access-rights and protection faults. Independent read and write wait-state counts are kept. Sits behind the APB master/decoder as one PSEL target.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_wait_ctrl.sv | 62 ++++++
 rtl/apb4_regfile_slave.sv | 110 +++++++++++
 tb/tb_apb4_regfile_slave.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB slave state/error types and limits.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_e;

    typedef enum logic [2:0] {ERR_NONE, ERR_DECODE, ERR_ALIGN, ERR_RO, ERR_PROT} apb_err_e;

    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/apb_wait_ctrl.sv
// apb_wait_ctrl: APB transfer FSM with independent read/write wait-state counts.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int WAIT_WRITE = 0,
    parameter int WAIT_READ  = 0
) (
    input  logic i_pclk,
    input  logic i_prstn,
    input  logic i_psel,
    input  logic i_penable,
    input  logic i_pwrite,
    output logic o_pready,
    output logic o_load,
    output logic o_complete
);

    apb_state_e state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       wr, wr_nx;
    logic       setup;
    logic [3:0] wait_lim;

    assign setup    = i_psel & ~i_penable;
    assign wait_lim = wr ? 4'(WAIT_WRITE) : 4'(WAIT_READ);

    always_ff @(posedge i_pclk or negedge i_prstn) begin
        if (!i_prstn) begin
            state <= IDLE;
            cnt   <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            wr    <= wr_nx;
        end
    end

    // a setup cycle restarts the transfer from any state; losing psel aborts it
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_nx    = wr;
        if (setup) begin
            cnt_nx   = '0;
            wr_nx    = i_pwrite;
            state_nx = ((i_pwrite ? WAIT_WRITE : WAIT_READ) == 0) ? READY : WAIT;
        end else if (!i_psel) begin
            state_nx = IDLE;
        end else if (state == WAIT) begin
            cnt_nx   = cnt + 4'd1;
            state_nx = (cnt == wait_lim - 4'd1) ? READY : WAIT;
        end else if (state == READY) begin
            state_nx = IDLE;
        end
    end

    assign o_pready   = state == READY;
    assign o_complete = (state == READY) & i_psel & i_penable;
    assign o_load     = (state_nx == READY) & ((state != READY) | setup);

endmodule

// File: rtl/apb4_regfile_slave.sv
// apb4_regfile_slave: APB4 register file with strobes, protection checks,
// read-only status window and PSLVERR reporting.
module apb4_regfile_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int RO_REGS    = 4,
    parameter int PRIV_BASE  = DEPTH,
    parameter int WAIT_WRITE = 0,
    parameter int WAIT_READ  = 0
) (
    input  logic                                            i_pclk,
    input  logic                                            i_prstn,
    input  logic [ADDR_WIDTH-1:0]                           i_paddr,
    input  logic                                            i_pwrite,
    input  logic                                            i_psel,
    input  logic                                            i_penable,
    input  logic [DATA_WIDTH-1:0]                           i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]                         i_pstrb,
    input  logic [2:0]                                      i_pprot,
    input  logic [(RO_REGS > 0 ? RO_REGS : 1)*DATA_WIDTH-1:0] i_status,
    output logic [DATA_WIDTH-1:0]                           o_prdata,
    output logic                                            o_pready,
    output logic                                            o_pslverr,
    output logic [(DEPTH-RO_REGS)*DATA_WIDTH-1:0]           o_regs
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int WORD_LEN = $clog2(BYTES);
    localparam int IW       = $clog2(DEPTH);
    localparam int RW_N     = DEPTH - RO_REGS;
    localparam int MW       = RW_N > 1 ? $clog2(RW_N) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

    logic [DATA_WIDTH-1:0] mem [RW_N];
    logic [IW-1:0]         cur_idx, idx_q, src_idx;
    logic [MW-1:0]         rw_idx;
    apb_err_e              cur_err, err_q, src_err;
    logic                  wr_q, src_wr;
    logic                  setup, load, complete;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_pprot;

    assign unused_pprot = &{1'b0, i_pprot[2:1]};

    apb_wait_ctrl #(
        .WAIT_WRITE(WAIT_WRITE),
        .WAIT_READ (WAIT_READ)
    ) u_wait (
        .i_pclk    (i_pclk),
        .i_prstn   (i_prstn),
        .i_psel    (i_psel),
        .i_penable (i_penable),
        .i_pwrite  (i_pwrite),
        .o_pready  (o_pready),
        .o_load    (load),
        .o_complete(complete)
    );

    assign setup   = i_psel & ~i_penable;
    assign cur_idx = i_paddr[WORD_LEN +: IW];
    assign cur_err = ({1'b0, i_paddr} >= LIMIT)                  ? ERR_DECODE :
                     (i_paddr[WORD_LEN-1:0] != '0)              ? ERR_ALIGN  :
                     (i_pwrite && int'(cur_idx) < RO_REGS)      ? ERR_RO     :
                     (int'(cur_idx) >= PRIV_BASE && !i_pprot[0]) ? ERR_PROT   : ERR_NONE;

    always_ff @(posedge i_pclk or negedge i_prstn) begin
        if (!i_prstn) begin
            idx_q <= '0;
            err_q <= ERR_NONE;
            wr_q  <= 1'b0;
        end else if (setup) begin
            idx_q <= cur_idx;
            err_q <= cur_err;
            wr_q  <= i_pwrite;
        end
    end

    // with zero wait states READY is entered on the setup edge itself, so use live decode then
    assign src_idx = setup ? cur_idx : idx_q;
    assign src_err = setup ? cur_err : err_q;
    assign src_wr  = setup ? i_pwrite : wr_q;
    assign rw_idx  = MW'(src_idx - IW'(RO_REGS));
    assign rd_word = (src_err != ERR_NONE)  ? '0 :
                     (int'(src_idx) < RO_REGS) ? i_status[int'(src_idx)*DATA_WIDTH +: DATA_WIDTH] :
                     mem[rw_idx];

    always_ff @(posedge i_pclk or negedge i_prstn) begin
        if (!i_prstn) o_prdata <= '0;
        else if (load && !src_wr) o_prdata <= rd_word;
    end

    always_ff @(posedge i_pclk or negedge i_prstn) begin
        if (!i_prstn) begin
            for (int i = 0; i < RW_N; i++) mem[i] <= '0;
        end else if (complete && wr_q && err_q == ERR_NONE) begin
            for (int b = 0; b < BYTES; b++)
                if (i_pstrb[b]) mem[rw_idx][8*b +: 8] <= i_pwdata[8*b +: 8];
        end
    end

    assign o_pslverr = o_pready & (err_q != ERR_NONE);

    for (genvar g = 0; g < RW_N; g++) begin : g_regs
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// tb_apb4_regfile_slave: directed vector table plus multi-cycle sequences
// against a zero-wait instance (A) and a wait-state instance (B).
module tb_apb4_regfile_slave;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pwrite = 1'b0, penable = 1'b0, sel_a = 1'b0, sel_b = 1'b0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [127:0] status = {32'h5A000003, 32'h5A000002, 32'h5A000001, 32'h5A000000};
    logic [31:0] rd_a, rd_b;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [895:0] regs_a, regs_b;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    apb4_regfile_slave #(.PRIV_BASE(16)) dut_a (
        .i_pclk(clk), .i_prstn(rstn), .i_paddr(paddr), .i_pwrite(pwrite), .i_psel(sel_a),
        .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb), .i_pprot(pprot),
        .i_status(status), .o_prdata(rd_a), .o_pready(rdy_a), .o_pslverr(err_a), .o_regs(regs_a)
    );

    apb4_regfile_slave #(.WAIT_WRITE(5), .WAIT_READ(3)) dut_b (
        .i_pclk(clk), .i_prstn(rstn), .i_paddr(paddr), .i_pwrite(pwrite), .i_psel(sel_b),
        .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb), .i_pprot(pprot),
        .i_status(status), .o_prdata(rd_b), .o_pready(rdy_b), .o_pslverr(err_b), .o_regs(regs_b)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic [2:0] p, logic [31:0] r, bit e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.prot = p; v.rdata = r; v.err = e;
        return v;
    endfunction

    // enters 1 time unit after a rising edge; leaves the bus idle at the same point
    task automatic xfer(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic e, output int lat);
        paddr = addr; pwdata = data; pwrite = wr; pstrb = strb; pprot = prot;
        penable = 1'b0; sel_a = !b; sel_b = b;
        @(posedge clk); #1 penable = 1'b1;
        lat = 0; rd = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (b ? rdy_b : rdy_a) begin
                lat = i; rd = b ? rd_b : rd_a; e = b ? err_b : err_a;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
        penable = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat, hits;

    initial begin
        tbl[0]  = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 0);
        tbl[1]  = mk(0, 32'h10, 32'h0,        4'h0, 3'd0, 32'hDEADBEEF, 0);
        tbl[2]  = mk(1, 32'h20, 32'h11223344, 4'hF, 3'd0, 32'h0, 0);
        tbl[3]  = mk(1, 32'h20, 32'hAABBCCDD, 4'h5, 3'd0, 32'h0, 0);
        tbl[4]  = mk(0, 32'h20, 32'h0,        4'h0, 3'd0, 32'h11BB33DD, 0);
        tbl[5]  = mk(1, 32'h24, 32'h12345678, 4'h0, 3'd0, 32'h0, 0);
        tbl[6]  = mk(0, 32'h24, 32'h0,        4'h0, 3'd0, 32'h0, 0);
        tbl[7]  = mk(1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0, 1);
        tbl[8]  = mk(0, 32'h00, 32'h0,        4'h0, 3'd0, 32'h5A000000, 0);
        tbl[9]  = mk(0, 32'h0C, 32'h0,        4'h0, 3'd0, 32'h5A000003, 0);
        tbl[10] = mk(0, 32'h13, 32'h0,        4'h0, 3'd0, 32'h0, 1);
        tbl[11] = mk(1, 32'h40, 32'h55,       4'hF, 3'd0, 32'h0, 1);
        tbl[12] = mk(0, 32'h40, 32'h0,        4'h0, 3'd1, 32'h0, 0);
        tbl[13] = mk(0, 32'h40, 32'h0,        4'h0, 3'd0, 32'h0, 1);
        tbl[14] = mk(1, 32'h40, 32'h55,       4'hF, 3'd1, 32'h0, 0);
        tbl[15] = mk(0, 32'h40, 32'h0,        4'h0, 3'd1, 32'h55, 0);
        tbl[16] = mk(0, 32'h80, 32'h0,        4'h0, 3'd1, 32'h0, 1);
        tbl[17] = mk(1, 32'h7C, 32'hCAFEF00D, 4'hF, 3'd1, 32'h0, 0);
        tbl[18] = mk(0, 32'h7C, 32'h0,        4'h0, 3'd1, 32'hCAFEF00D, 0);
        tbl[19] = mk(1, 32'h03, 32'h1,        4'hF, 3'd0, 32'h0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready_a", {31'b0, rdy_a}, 32'h0);
        chk("rst_pslverr_a", {31'b0, err_a}, 32'h0);
        chk("rst_prdata_a", rd_a, 32'h0);
        chk("rst_regs_a", {31'b0, |regs_a}, 32'h0);
        chk("rst_pready_b", {31'b0, rdy_b}, 32'h0);
        chk("rst_prdata_b", rd_b, 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // back-to-back zero-wait transfers on A
        foreach (tbl[i]) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot, rd, e, lat);
            chk($sformatf("v%0d_lat", i), lat, 32'd1);
            chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, tbl[i].err});
            if (!tbl[i].wr) chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
        end
        chk("regs_a_w4", regs_a[0*32 +: 32], 32'hDEADBEEF);
        chk("regs_a_w8", regs_a[4*32 +: 32], 32'h11BB33DD);
        chk("regs_a_w16", regs_a[12*32 +: 32], 32'h55);
        chk("regs_a_w31", regs_a[27*32 +: 32], 32'hCAFEF00D);

        // wait-state instance: write takes 5 waits, read 3
        xfer(1, 1, 32'h14, 32'h0BADF00D, 4'hF, 3'd0, rd, e, lat);
        chk("b_wr_lat", lat, 32'd6);
        chk("b_wr_err", {31'b0, e}, 32'h0);
        chk("b_regs_w5", regs_b[1*32 +: 32], 32'h0BADF00D);
        xfer(1, 0, 32'h14, 32'h0, 4'h0, 3'd0, rd, e, lat);
        chk("b_rd_lat", lat, 32'd4);
        chk("b_rd_data", rd, 32'h0BADF00D);
        @(negedge clk);
        chk("b_pready_one_cycle", {31'b0, rdy_b}, 32'h0);
        @(posedge clk); #1;

        // drop psel after two access cycles of a waited write
        paddr = 32'h18; pwdata = 32'h77; pwrite = 1'b1; pstrb = 4'hF; sel_b = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        hits = 0;
        repeat (2) begin
            @(negedge clk); hits += int'(rdy_b);
            @(posedge clk); #1;
        end
        sel_b = 1'b0; penable = 1'b0;
        repeat (8) begin
            @(negedge clk); hits += int'(rdy_b);
        end
        chk("abort_pready", hits, 32'd0);
        chk("abort_no_write", regs_b[2*32 +: 32], 32'h0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a waited write
        paddr = 32'h1C; pwdata = 32'h99; pwrite = 1'b1; pstrb = 4'hF; sel_b = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_pready", {31'b0, rdy_b}, 32'h0);
        chk("midrst_pslverr", {31'b0, err_b}, 32'h0);
        chk("midrst_prdata", rd_b, 32'h0);
        chk("midrst_regs", {31'b0, |regs_b}, 32'h0);
        sel_b = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 32'h1C, 32'h0, 4'h0, 3'd0, rd, e, lat);
        chk("midrst_no_write", rd, 32'h0);
        xfer(1, 0, 32'h14, 32'h0, 4'h0, 3'd0, rd, e, lat);
        chk("midrst_cleared", rd, 32'h0);
        chk("b_rd_lat2", lat, 32'd4);
        xfer(1, 0, 32'h08, 32'h0, 4'h0, 3'd0, rd, e, lat);
        chk("b_status_w2", rd, 32'h5A000002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
